// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline register between adjacent stages: valid/ready handshake,
// flush to a bubble pattern, optional one-entry skid buffer and perf counters.
module pipe_stage_reg #(
   parameter int               WIDTH    = 32,
   parameter int               NFIELD   = 5,
   parameter int               PC_FIELD = 1,
   parameter logic [WIDTH-1:0] RESET_PC = 32'h00003000,
   parameter bit               SKID     = 1'b1,
   parameter int               CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NFIELD*WIDTH-1:0] in_data,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [NFIELD*WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]        xfer_cnt,
   output logic [CNT_W-1:0]        bubble_cnt
);

   localparam int TOTAL = NFIELD * WIDTH;
   localparam logic [TOTAL-1:0] BUBBLE = TOTAL'(RESET_PC) << (PC_FIELD * WIDTH);

   logic             main_valid;
   logic [TOTAL-1:0] main_data;
   logic             skid_valid;
   logic [TOTAL-1:0] skid_data;
   logic             rdy_q;
   logic             in_xfer;
   logic             out_xfer;
   logic             load_main;

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = main_valid & out_ready;
   assign load_main = ~main_valid | out_ready;

   // rdy_q is low in reset and mirrors ~skid_valid afterwards, so it also
   // provides the "ready from the first cycle after release" behaviour.
   if (SKID) begin : g_skid
      assign in_ready = rdy_q & ~flush;
   end else begin : g_plain
      assign in_ready = rdy_q & (out_ready | ~main_valid) & ~flush;
   end

   // The skid entry only ever fills while the main register is stalled, so
   // when the main register can load, a waiting skid payload is always older.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         main_valid <= 1'b0;
         main_data  <= BUBBLE;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         rdy_q      <= 1'b0;
      end else if (flush) begin
         main_valid <= 1'b0;
         main_data  <= BUBBLE;
         skid_valid <= 1'b0;
         rdy_q      <= 1'b1;
      end else if (load_main) begin
         if (skid_valid) begin
            main_data  <= skid_data;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_xfer) begin
            main_data  <= in_data;
            main_valid <= 1'b1;
         end else begin
            main_valid <= 1'b0;
         end
         rdy_q <= 1'b1;
      end else if (in_xfer && SKID) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
         rdy_q      <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xfer_cnt   <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_xfer) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         end
         if (out_ready && !main_valid) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
      end
   end

   assign out_valid = main_valid;
   assign out_data  = main_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid instance (4-bit counters) with a payload
// scoreboard, and a plain-register instance for the combinational ready path.
module tb_pipe_stage_reg;

   localparam logic [159:0] BUBBLE = {96'h0, 32'h00003000, 32'h0};

   logic         clk;
   logic         reset;

   logic         s_in_valid, s_in_ready, s_flush, s_out_valid, s_out_ready;
   logic [159:0] s_in_data, s_out_data;
   logic [3:0]   s_xfer, s_bubble;

   logic         p_in_valid, p_in_ready, p_flush, p_out_valid, p_out_ready;
   logic [159:0] p_in_data, p_out_data;
   logic [31:0]  p_xfer, p_bubble;

   int           n_cmp;
   int           n_err;
   int           exp_xfer;
   logic [159:0] sb[$];
   logic [159:0] sb_exp;

   pipe_stage_reg #(.SKID(1'b1), .CNT_W(4)) u_skid (
      .clk(clk), .reset(reset),
      .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
      .flush(s_flush),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
      .xfer_cnt(s_xfer), .bubble_cnt(s_bubble)
   );

   pipe_stage_reg #(.SKID(1'b0), .CNT_W(32)) u_plain (
      .clk(clk), .reset(reset),
      .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
      .flush(p_flush),
      .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
      .xfer_cnt(p_xfer), .bubble_cnt(p_bubble)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [159:0] mk(input int n);
      logic [159:0] d;
      d[31:0]    = 32'(n);
      d[63:32]   = 32'h1000 + 32'(4 * n);
      d[95:64]   = 32'(n * 3);
      d[127:96]  = ~32'(n);
      d[159:128] = 32'hA500_0000 | 32'(n);
      return d;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Inputs change just after a rising edge, so the falling edge sees exactly
   // what the next rising edge will sample.
   always @(negedge clk) begin
      if (!reset) begin
         sb.delete();
      end else begin
         if (s_out_valid && s_out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_err++;
               $display("[TB] FAIL sb_unexpected: got %h expected no output", s_out_data);
            end else begin
               sb_exp = sb.pop_front();
               if (s_out_data !== sb_exp) begin
                  n_err++;
                  $display("[TB] FAIL sb_data: got %h expected %h", s_out_data, sb_exp);
               end
            end
         end
         if (s_flush) sb.delete();
         else if (s_in_valid && s_in_ready) sb.push_back(s_in_data);
      end
   end

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) tick();
      n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rst_s_in_ready: got %b expected 0", s_in_ready); end
      n_cmp++; if (p_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL rst_p_in_ready: got %b expected 0", p_in_ready); end
      reset = 1'b1;
      tick();
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rst_out_valid: got %b expected 0", s_out_valid); end
      n_cmp++; if (s_out_data !== BUBBLE) begin n_err++; $display("[TB] FAIL rst_out_data: got %h expected %h", s_out_data, BUBBLE); end
      n_cmp++; if (p_out_data !== BUBBLE) begin n_err++; $display("[TB] FAIL rst_p_out_data: got %h expected %h", p_out_data, BUBBLE); end
      n_cmp++; if (s_xfer !== 4'd0 || s_bubble !== 4'd0) begin n_err++; $display("[TB] FAIL rst_counters: got %0d/%0d expected 0/0", s_xfer, s_bubble); end
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_release_s_ready: got %b expected 1", s_in_ready); end
      n_cmp++; if (p_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL rst_release_p_ready: got %b expected 1", p_in_ready); end
   endtask

   task automatic test_streaming;
      s_out_ready = 1'b1;
      s_in_valid  = 1'b1;
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stream_pre_valid: got %b expected 0", s_out_valid); end
      for (int i = 1; i <= 8; i++) begin
         s_in_data = mk(i);
         n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL stream_in_ready[%0d]: got %b expected 1", i, s_in_ready); end
         tick();
         n_cmp++; if (s_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL stream_valid[%0d]: got %b expected 1", i, s_out_valid); end
         n_cmp++; if (s_out_data !== mk(i)) begin n_err++; $display("[TB] FAIL stream_data[%0d]: got %h expected %h", i, s_out_data, mk(i)); end
      end
      s_in_valid = 1'b0;
      tick();
      exp_xfer += 8;
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL stream_drained: got %b expected 0", s_out_valid); end
      n_cmp++; if (s_xfer !== 4'(exp_xfer)) begin n_err++; $display("[TB] FAIL stream_xfer_cnt: got %0d expected %0d", s_xfer, exp_xfer); end
      n_cmp++; if (s_bubble !== 4'd1) begin n_err++; $display("[TB] FAIL stream_bubble_cnt: got %0d expected 1", s_bubble); end
      s_out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      s_in_valid = 1'b1;
      s_in_data  = mk(10);
      tick();
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_ready_a: got %b expected 1", s_in_ready); end
      s_in_data = mk(11);
      tick();
      s_in_valid = 1'b0;
      n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL bp_ready_full: got %b expected 0", s_in_ready); end
      n_cmp++; if (s_out_data !== mk(10)) begin n_err++; $display("[TB] FAIL bp_hold_a: got %h expected %h", s_out_data, mk(10)); end
      tick();
      n_cmp++; if (s_out_data !== mk(10) || s_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_stall_a: got %h/%b expected %h/1", s_out_data, s_out_valid, mk(10)); end
      s_out_ready = 1'b1;
      tick();
      n_cmp++; if (s_out_data !== mk(11) || s_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_out_b: got %h/%b expected %h/1", s_out_data, s_out_valid, mk(11)); end
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL bp_ready_back: got %b expected 1", s_in_ready); end
      tick();
      exp_xfer += 2;
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL bp_drained: got %b expected 0", s_out_valid); end
      s_out_ready = 1'b0;
   endtask

   task automatic test_comb_stall;
      p_out_ready = 1'b0;
      p_in_valid  = 1'b1;
      p_in_data   = mk(30);
      #1;
      n_cmp++; if (p_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL cs_ready_empty: got %b expected 1", p_in_ready); end
      tick();
      p_in_data = mk(31);
      #1;
      n_cmp++; if (p_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL cs_ready_lo: got %b expected 0", p_in_ready); end
      p_out_ready = 1'b1;
      #1;
      n_cmp++; if (p_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL cs_ready_follow: got %b expected 1", p_in_ready); end
      p_flush = 1'b1;
      #1;
      n_cmp++; if (p_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL cs_ready_flush: got %b expected 0", p_in_ready); end
      p_flush     = 1'b0;
      p_out_ready = 1'b0;
      #1;
      n_cmp++; if (p_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL cs_ready_drop: got %b expected 0", p_in_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (p_out_data !== mk(30) || p_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL cs_stall[%0d]: got %h/%b expected %h/1", i, p_out_data, p_out_valid, mk(30)); end
      end
      p_out_ready = 1'b1;
      tick();
      p_in_valid = 1'b0;
      n_cmp++; if (p_out_data !== mk(31) || p_out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL cs_pass: got %h/%b expected %h/1", p_out_data, p_out_valid, mk(31)); end
      tick();
      n_cmp++; if (p_out_valid !== 1'b0 || p_out_data !== mk(31)) begin n_err++; $display("[TB] FAIL cs_empty_hold: got %h/%b expected %h/0", p_out_data, p_out_valid, mk(31)); end
      p_out_ready = 1'b0;
   endtask

   task automatic test_flush_priority;
      s_in_valid = 1'b1;
      s_in_data  = mk(20);
      tick();
      s_in_data = mk(21);
      tick();
      n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL fl_skid_full: got %b expected 0", s_in_ready); end
      s_flush     = 1'b1;
      s_in_data   = mk(22);
      s_out_ready = 1'b1;
      tick();
      exp_xfer += 1;
      s_flush    = 1'b0;
      s_in_valid = 1'b0;
      #1;
      n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL fl_valid: got %b expected 0", s_out_valid); end
      n_cmp++; if (s_out_data !== BUBBLE) begin n_err++; $display("[TB] FAIL fl_bubble: got %h expected %h", s_out_data, BUBBLE); end
      n_cmp++; if (s_in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL fl_skid_empty: got %b expected 1", s_in_ready); end
      n_cmp++; if (s_xfer !== 4'(exp_xfer)) begin n_err++; $display("[TB] FAIL fl_xfer_cnt: got %0d expected %0d", s_xfer, 4'(exp_xfer)); end
      s_flush = 1'b1;
      #1;
      n_cmp++; if (s_in_ready !== 1'b0) begin n_err++; $display("[TB] FAIL fl_ready_in_flush: got %b expected 0", s_in_ready); end
      s_flush = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         n_cmp++; if (s_out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL fl_no_leak[%0d]: got %b expected 0", i, s_out_valid); end
      end
      s_out_ready = 1'b0;
   endtask

   task automatic test_counter_wrap;
      s_in_valid = 1'b1;
      s_in_data  = mk(40);
      tick();
      s_in_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      n_cmp++; if (s_out_valid !== 1'b0 || s_out_data !== BUBBLE) begin n_err++; $display("[TB] FAIL async_reset: got %h/%b expected %h/0", s_out_data, s_out_valid, BUBBLE); end
      repeat (2) tick();
      reset = 1'b1;
      tick();
      n_cmp++; if (s_xfer !== 4'd0 || s_bubble !== 4'd0) begin n_err++; $display("[TB] FAIL wrap_start: got %0d/%0d expected 0/0", s_xfer, s_bubble); end
      s_out_ready = 1'b1;
      repeat (16) tick();
      n_cmp++; if (s_bubble !== 4'd0) begin n_err++; $display("[TB] FAIL wrap_16: got %0d expected 0", s_bubble); end
      tick();
      n_cmp++; if (s_bubble !== 4'd1) begin n_err++; $display("[TB] FAIL wrap_17: got %0d expected 1", s_bubble); end
      n_cmp++; if (s_xfer !== 4'd0) begin n_err++; $display("[TB] FAIL wrap_xfer: got %0d expected 0", s_xfer); end
      s_out_ready = 1'b0;
   endtask

   initial begin
      n_cmp = 0; n_err = 0; exp_xfer = 0;
      reset = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_flush = 1'b0; s_out_ready = 1'b0;
      p_in_valid = 1'b0; p_in_data = '0; p_flush = 1'b0; p_out_ready = 1'b0;
      $display("[TB] starting pipe_stage_reg bench");
      test_reset();
      test_streaming();
      test_backpressure();
      test_comb_stall();
      test_flush_priority();
      test_counter_wrap();
      tick();
      n_cmp++; if (sb.size() != 0) begin n_err++; $display("[TB] FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised successor to the fixed M-to-W pipeline register.
- Carries NFIELD payload fields of WIDTH bits between adjacent pipeline stages.
- Adds a valid/ready handshake, stall by backpressure, synchronous flush, a defined reset value for the PC field, and an optional one-entry skid buffer.
- Also exposes transfer and bubble performance counters. Usable for any of the F/D, D/E, E/M or M/W boundaries.

Parameters:
- WIDTH, 32, bits per payload field.
- NFIELD, 5, number of payload fields; field k occupies bits [k*WIDTH +: WIDTH].
- PC_FIELD, 1, index of the field that holds the PC; it resets and flushes to RESET_PC.
- RESET_PC, 32'h00003000, value loaded into PC_FIELD on reset and on flush.
- SKID, 1, 1 = one-entry skid buffer (registered in_ready); 0 = plain register.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has a payload
- in_ready  out  1  this stage accepts the payload this cycle
- in_data  in  NFIELD*WIDTH  upstream payload
- flush  in  1  synchronous kill of all held payloads
- out_valid  out  1  output payload is valid
- out_ready  in  1  downstream accepts the output
- out_data  out  NFIELD*WIDTH  output payload
- xfer_cnt  out  CNT_W  count of output handshakes
- bubble_cnt  out  CNT_W  count of cycles with out_ready=1 and out_valid=0

Behaviour:
- Handshakes:
  - An input transfer occurs when in_valid and in_ready are both 1 at a rising edge.
  - An output transfer occurs when out_valid and out_ready are both 1 at a rising edge.
  - Payload is never duplicated or dropped except by flush.
- Reset (reset=0, asynchronous):
  - out_valid=0; skid entry is invalid.
  - All out_data fields are 0 except PC_FIELD, which is RESET_PC.
  - xfer_cnt=0, bubble_cnt=0.
  - in_ready=0 while reset is asserted; in_ready=1 on the first cycle after release.
  - Asserting reset mid-transfer discards all held state.
- SKID=0:
  - in_ready = (out_ready | ~out_valid) & ~flush. This path is combinational from out_ready.
  - On an input transfer, out_data and out_valid take the input on the next edge (1-cycle latency).
  - On an output transfer with no input transfer, out_valid goes to 0 and out_data holds its value.
  - Otherwise out_data and out_valid hold, which stalls the stage.
- SKID=1:
  - in_ready = ~skid_valid & ~flush, registered; there is no combinational path from out_ready to in_ready.
  - If an input transfer occurs while out_valid=1 and out_ready=0, the payload goes into the skid entry and skid_valid becomes 1.
  - When the output transfers and skid_valid=1, the skid payload moves to out_data on the next edge and skid_valid goes to 0.
  - Throughput is one transfer per cycle when out_ready stays 1; latency is 1 cycle.
  - Ordering is FIFO: the main register is always older than the skid entry.
- Flush (sampled at the edge):
  - Next state: out_valid=0, skid_valid=0.
  - out_data loads the bubble pattern: all fields 0 (instruction field = nop) except PC_FIELD = RESET_PC.
  - flush takes priority over a simultaneous input or output transfer.
  - The output transfer in the flush cycle still counts in xfer_cnt; the input is discarded.
  - in_ready=0 during the flush cycle.
- Counters:
  - xfer_cnt increments on each output transfer.
  - bubble_cnt increments on each edge where out_ready=1 and out_valid=0.
  - Both wrap modulo 2^CNT_W with no saturation and are unaffected by flush.
- out_data must not change while out_valid=1 and out_ready=0 (stall stability), except on flush.

Test Plan:
- Reset check: hold reset=0 for 3 cycles, then release -> out_valid=0, PC field = 32'h00003000, all other fields 0, both counters 0; in_ready=1 on the first cycle after release.
- Streaming: SKID=1, out_ready=1, drive 8 back-to-back payloads with the instruction field set to 1..8 -> out_valid rises 1 cycle after the first; outputs appear in order 1..8 on consecutive cycles; xfer_cnt=8; in_ready never drops.
- Backpressure: SKID=1, out_ready=0 while sending payloads A then B -> A held on out_data, B in skid, in_ready=0 on the next cycle. Then out_ready=1 -> A, then B, no loss; in_ready returns to 1 once the skid entry drains.
- Combinational stall: SKID=0, out_valid=1, toggle out_ready -> in_ready follows out_ready in the same cycle; with out_ready=0, out_data is unchanged for 4 cycles.
- Flush priority: skid entry full, then pulse flush together with in_valid=1 and out_ready=1 -> next cycle out_valid=0, skid empty, out_data = bubble pattern with PC = 32'h00003000; xfer_cnt increments by 1; the input payload never appears on the output.
- Counter wrap: CNT_W=4, out_ready=1, in_valid=0 for 17 cycles -> bubble_cnt wraps and reads 1.
